// File: rtl/secuenciador_morse_pkg.sv
// Shared types and unit constants for the Morse keying stage.
// Segment lengths are stored as "units minus one" so they compare directly against cuenta.
package secuenciador_morse_pkg;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        ELEMENTO  = 2'd1,
        PAUSA     = 2'd2,
        PAUSA_CAR = 2'd3
    } estado_t;

    localparam logic [4:0] UNID_PUNTO     = 5'd0;
    localparam logic [4:0] UNID_RAYA      = 5'd2;
    localparam logic [4:0] UNID_PAUSA     = 5'd0;
    localparam logic [4:0] UNID_PAUSA_CAR = 5'd2;
    localparam int         MAX_LONG       = 5;

    function automatic logic [4:0] unidades_elemento(input logic es_raya);
        return es_raya ? UNID_RAYA : UNID_PUNTO;
    endfunction

endpackage

// File: rtl/secuenciador_morse_tick.sv
// Prescaler producing one tick every DIV_TICK clocks.
// A clear realigns the unit grid to the start of a new character.
module generador_tick #(
    parameter int DIV_TICK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DIV_TICK);

    logic [W-1:0] pre_q;

    assign tick = (pre_q == W'(DIV_TICK - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (clr || tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

endmodule

// File: rtl/secuenciador_morse.sv
// Keys one Morse character (1..5 elements) with unit timing; segment ends come from
// an external equality comparator watching cuenta against objetivo.
module secuenciador_morse
    import secuenciador_morse_pkg::*;
#(
    parameter int DIV_TICK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inicio,
    input  logic [4:0] simbolo,
    input  logic [2:0] longitud,
    input  logic       fin_cuenta,
    output logic [4:0] cuenta,
    output logic [4:0] objetivo,
    output logic       salida_morse,
    output logic       ocupado,
    output logic       listo
);
    estado_t    estado_q, estado_d;
    logic [4:0] cuenta_q, cuenta_d;
    logic [4:0] objetivo_q, objetivo_d;
    logic [4:0] simbolo_q, simbolo_d;
    logic [2:0] indice_q, indice_d;
    logic       salida_q, salida_d;
    logic       ocupado_q, ocupado_d;
    logic       listo_q, listo_d;
    logic       tick;
    logic       clr_tick;
    logic       peticion_valida;

    generador_tick #(.DIV_TICK(DIV_TICK)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_tick),
        .tick  (tick)
    );

    assign peticion_valida = inicio && (longitud != 3'd0) && (longitud <= 3'(MAX_LONG));

    always_comb begin
        estado_d   = estado_q;
        cuenta_d   = cuenta_q;
        objetivo_d = objetivo_q;
        simbolo_d  = simbolo_q;
        indice_d   = indice_q;
        salida_d   = salida_q;
        ocupado_d  = ocupado_q;
        listo_d    = 1'b0;
        clr_tick   = 1'b0;

        if (estado_q == REPOSO) begin
            if (peticion_valida) begin
                simbolo_d  = simbolo;
                indice_d   = longitud - 3'd1;
                objetivo_d = unidades_elemento(simbolo[longitud - 3'd1]);
                cuenta_d   = 5'd0;
                salida_d   = 1'b1;
                ocupado_d  = 1'b1;
                clr_tick   = 1'b1;
                estado_d   = ELEMENTO;
            end
        end else if (tick) begin
            if (!fin_cuenta) begin
                cuenta_d = cuenta_q + 5'd1;
            end else begin
                cuenta_d = 5'd0;
                case (estado_q)
                    ELEMENTO: begin
                        salida_d = 1'b0;
                        if (indice_q != 3'd0) begin
                            estado_d   = PAUSA;
                            objetivo_d = UNID_PAUSA;
                        end else begin
                            estado_d   = PAUSA_CAR;
                            objetivo_d = UNID_PAUSA_CAR;
                        end
                    end
                    PAUSA: begin
                        indice_d   = indice_q - 3'd1;
                        objetivo_d = unidades_elemento(simbolo_q[indice_q - 3'd1]);
                        salida_d   = 1'b1;
                        estado_d   = ELEMENTO;
                    end
                    PAUSA_CAR: begin
                        ocupado_d = 1'b0;
                        listo_d   = 1'b1;
                        estado_d  = REPOSO;
                    end
                    default: estado_d = REPOSO;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q   <= REPOSO;
            cuenta_q   <= 5'd0;
            objetivo_q <= 5'd0;
            simbolo_q  <= 5'd0;
            indice_q   <= 3'd0;
            salida_q   <= 1'b0;
            ocupado_q  <= 1'b0;
            listo_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cuenta_q   <= cuenta_d;
            objetivo_q <= objetivo_d;
            simbolo_q  <= simbolo_d;
            indice_q   <= indice_d;
            salida_q   <= salida_d;
            ocupado_q  <= ocupado_d;
            listo_q    <= listo_d;
        end
    end

    assign cuenta       = cuenta_q;
    assign objetivo     = objetivo_q;
    assign salida_morse = salida_q;
    assign ocupado      = ocupado_q;
    assign listo        = listo_q;

endmodule

// File: tb/tb_secuenciador_morse.sv
// Directed bench for the Morse keying stage with DIV_TICK=4 and an ideal comparator.
module tb_secuenciador_morse;

    logic       clk;
    logic       rst_n;
    logic       inicio;
    logic [4:0] simbolo;
    logic [2:0] longitud;
    logic       fin_cuenta;
    logic [4:0] cuenta;
    logic [4:0] objetivo;
    logic       salida_morse;
    logic       ocupado;
    logic       listo;

    int checks   = 0;
    int failures = 0;

    int runs[$];
    int exp_runs[$];
    int cuentas[$];
    int objs[$];
    int nclk;
    int first_level;

    secuenciador_morse #(.DIV_TICK(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inicio       (inicio),
        .simbolo      (simbolo),
        .longitud     (longitud),
        .fin_cuenta   (fin_cuenta),
        .cuenta       (cuenta),
        .objetivo     (objetivo),
        .salida_morse (salida_morse),
        .ocupado      (ocupado),
        .listo        (listo)
    );

    assign fin_cuenta = (cuenta == objetivo);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a request so the next rising edge samples it; call away from posedge.
    task automatic start_char(input logic [4:0] sim, input logic [2:0] lon);
        simbolo  = sim;
        longitud = lon;
        inicio   = 1'b1;
        @(posedge clk);
        #1 inicio = 1'b0;
    endtask

    // Samples each negedge after acceptance until ocupado drops; optionally pokes a
    // conflicting request at sample poke_at.
    task automatic measure(input string tag, input int poke_at);
        int n;
        int lvl;
        n = 0;
        lvl = -1;
        runs.delete();
        cuentas.delete();
        objs.delete();
        first_level = -1;
        forever begin
            @(negedge clk);
            if (!ocupado || n >= 200) break;
            if (n == poke_at) begin
                simbolo = 5'b11111; longitud = 3'd5; inicio = 1'b1;
            end else begin
                inicio = 1'b0;
            end
            if (int'(salida_morse) != lvl) begin
                runs.push_back(1);
                lvl = int'(salida_morse);
                if (first_level < 0) first_level = lvl;
            end else begin
                runs[runs.size()-1] = runs[runs.size()-1] + 1;
            end
            cuentas.push_back(int'(cuenta));
            objs.push_back(int'(objetivo));
            n++;
        end
        inicio = 1'b0;
        nclk = n;
        chk({tag, "_timeout"}, int'(n < 200), 1);
        chk({tag, "_listo"}, int'(listo), 1);
        chk({tag, "_first_high"}, first_level, 1);
        chk({tag, "_nruns"}, runs.size(), exp_runs.size());
        for (int i = 0; i < exp_runs.size() && i < runs.size(); i++)
            chk($sformatf("%s_run%0d", tag, i), runs[i], exp_runs[i]);
        $display("char %s: busy %0d clocks, %0d runs", tag, n, runs.size());
    endtask

    initial begin
        int lh;
        rst_n = 1'b0; inicio = 1'b1; simbolo = 5'b00001; longitud = 3'd1;

        // Reset held with a pending request
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_salida", int'(salida_morse), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_listo", int'(listo), 0);
        chk("rst_cuenta", int'(cuenta), 0);
        chk("rst_objetivo", int'(objetivo), 0);
        inicio = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ocupado", int'(ocupado), 0);
        chk("idle_salida", int'(salida_morse), 0);
        $display("reset done");

        // 'E': dot then character gap
        start_char(5'b00000, 3'd1);
        exp_runs = '{4, 12};
        measure("E", -1);
        chk("E_total", nclk, 16);
        @(negedge clk);
        chk("E_listo_one_cycle", int'(listo), 0);

        // 'A' with a conflicting request in its first gap
        start_char(5'b00001, 3'd2);
        exp_runs = '{4, 4, 12, 12};
        measure("A", 6);
        chk("A_total", nclk, 32);
        chk("A_dash_obj", objs[8], 2);
        chk("A_dash_c0", cuentas[8], 0);
        chk("A_dash_c1", cuentas[12], 1);
        chk("A_dash_c2", cuentas[16], 2);
        chk("A_gap_obj", objs[4], 0);
        @(negedge clk);

        // '0': five dashes
        start_char(5'b11111, 3'd5);
        exp_runs = '{12, 4, 12, 4, 12, 4, 12, 4, 12, 12};
        measure("ZERO", -1);
        chk("ZERO_total", nclk, 88);
        @(negedge clk);

        // Out-of-range lengths are ignored
        foreach (exp_runs[i]) exp_runs[i] = 0;
        for (int k = 0; k < 2; k++) begin
            start_char(5'b10101, (k == 0) ? 3'd0 : 3'd6);
            lh = 0;
            repeat (6) begin
                @(negedge clk);
                lh += int'(ocupado) + int'(listo) + int'(salida_morse);
            end
            chk($sformatf("bad_len%0d_quiet", k), lh, 0);
            $display("rejected request %0d", k);
        end

        // Back-to-back: 'E' then 'T' requested during the listo cycle
        start_char(5'b00000, 3'd1);
        exp_runs = '{4, 12};
        measure("E2", -1);
        start_char(5'b00001, 3'd1);
        exp_runs = '{12, 12};
        measure("T", -1);
        chk("T_total", nclk, 24);
        @(negedge clk);

        // Abort in the second unit of the dash of 'A'
        start_char(5'b00001, 3'd2);
        repeat (14) @(negedge clk);
        chk("abort_pre_salida", int'(salida_morse), 1);
        chk("abort_pre_cuenta", int'(cuenta), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_salida", int'(salida_morse), 0);
        chk("abort_ocupado", int'(ocupado), 0);
        chk("abort_cuenta", int'(cuenta), 0);
        lh = 0;
        repeat (40) begin
            @(negedge clk);
            lh += int'(listo) + int'(ocupado);
        end
        chk("abort_no_listo", lh, 0);
        $display("abort done");

        start_char(5'b00000, 3'd1);
        exp_runs = '{4, 12};
        measure("E3", -1);
        chk("E3_total", nclk, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
